// File: rtl/div_pkg.sv
// div_pkg: shared state type, counter sizing and divide-by-zero constant for seq_divider.
package div_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

   localparam int MAX_W = 64;
   localparam logic [MAX_W-1:0] DIV0_QUOTIENT = '1;

   function automatic int count_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// carry_lookahead_adder: generate/propagate adder, sum = a + b + cin with carry-out.
module carry_lookahead_adder #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);

   logic [N-1:0] g;
   logic [N-1:0] p;
   logic [N:0]   c;

   assign g = a & b;
   assign p = a ^ b;

   always_comb begin
      c = '0;
      c[0] = cin;
      for (int i = 0; i < N; i++) c[i+1] = g[i] | (p[i] & c[i]);
   end

   assign sum  = p ^ c[N-1:0];
   assign cout = c[N];

endmodule

// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring divider, one quotient bit per clock.
// Define SIGNED_DIV_EN for two's-complement operands (adds one negation cycle).
module seq_divider
   import div_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero
);

   localparam int CW = count_w(N);

   div_state_t    state, state_nx;
   logic [CW-1:0] count;
   logic [N:0]    rreg, s, t, r_nx;
   logic [N-1:0]  qreg, dreg, q_nx;
   logic          cout, last, fin, unused_msb;

   assign s          = {rreg[N-1:0], qreg[N-1]};
   assign r_nx       = cout ? t : s;
   assign q_nx       = {qreg[N-2:0], cout};
   assign last       = (count == CW'(1));
   assign unused_msb = rreg[N];

   carry_lookahead_adder #(.N(N + 1)) u_sub (
      .a   (s),
      .b   (~{1'b0, dreg}),
      .cin (1'b1),
      .sum (t),
      .cout(cout)
   );

`ifdef SIGNED_DIV_EN
   logic sign_q, sign_r, fix;

   function automatic logic [N-1:0] mag(input logic [N-1:0] x);
      return x[N-1] ? -x : x;
   endfunction

   // the extra RUN cycle flagged by fix applies the sign correction
   assign fin = fix;
`else
   assign fin = last;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = (divisor == '0) ? DONE : RUN;
         RUN:     if (fin) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count       <= '0;
         rreg        <= '0;
         qreg        <= '0;
         dreg        <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         fix         <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (start) begin
`ifdef SIGNED_DIV_EN
               dreg   <= mag(divisor);
               qreg   <= mag(dividend);
               sign_q <= dividend[N-1] ^ divisor[N-1];
               sign_r <= dividend[N-1];
               fix    <= 1'b0;
`else
               dreg   <= divisor;
               qreg   <= dividend;
`endif
               rreg   <= '0;
               count  <= CW'(N);
               div_by_zero <= (divisor == '0);
               if (divisor == '0) begin
                  quotient  <= DIV0_QUOTIENT[N-1:0];
                  remainder <= dividend;
               end
            end
            RUN: begin
`ifdef SIGNED_DIV_EN
               if (fix) begin
                  quotient  <= sign_q ? -qreg : qreg;
                  remainder <= sign_r ? -rreg[N-1:0] : rreg[N-1:0];
               end else begin
                  rreg  <= r_nx;
                  qreg  <= q_nx;
                  count <= count - CW'(1);
                  fix   <= last;
               end
`else
               rreg  <= r_nx;
               qreg  <= q_nx;
               count <= count - CW'(1);
               if (last) begin
                  quotient  <= q_nx;
                  remainder <= r_nx[N-1:0];
               end
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider (fixed cases, ignored starts, reset abort, random).
module tb_seq_divider;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [N-1:0] dividend = '0;
   logic [N-1:0] divisor = '0;
   logic         busy, done, div_by_zero;
   logic [N-1:0] quotient, remainder;

   typedef struct packed {
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         z;
      logic [7:0]   lat;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   seq_divider #(.N(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
      exp_t e;
      if (b == '0) begin
         e.q = '1;
         e.r = a;
         e.z = 1'b1;
         e.lat = 8'd0;
      end else begin
`ifdef SIGNED_DIV_EN
         int sa, sd, qi, ri;
         sa = int'($signed(a));
         sd = int'($signed(b));
         qi = sa / sd;
         ri = sa % sd;
         e.q = qi[N-1:0];
         e.r = ri[N-1:0];
         e.lat = 8'(N + 1);
`else
         e.q = a / b;
         e.r = a % b;
         e.lat = 8'(N);
`endif
         e.z = 1'b0;
      end
      return e;
   endfunction

   task automatic check_result(input string tag, input exp_t e);
      check({tag, "_q"}, quotient, e.q);
      check({tag, "_r"}, remainder, e.r);
      check({tag, "_dz"}, div_by_zero, e.z);
   endtask

   task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b);
      exp_t e;
      int waited;
      @(posedge clk); #1;
      start = 1'b1;
      dividend = a;
      divisor = b;
      sb.push_back(model(a, b));
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_start", busy, 1);
      waited = 0;
      while (!done && waited < 40) begin
         @(posedge clk); #1;
         waited++;
      end
      e = sb.pop_front();
      check("latency", waited, e.lat);
      check_result("result", e);
      @(posedge clk); #1;
      check("done_pulse", done, 0);
      check("idle_after", busy, 0);
   endtask

   initial begin
      exp_t e;
      int dc;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_q", quotient, 0);
      check("rst_r", remainder, 0);
      check("rst_dz", div_by_zero, 0);
      rst_n = 1'b1;

      run_div(8'd100, 8'd7);
      run_div(8'd255, 8'd1);
      run_div(8'd3, 8'd200);
      run_div(8'd5, 8'd0);
      run_div(8'd9, 8'd3);

      // starts during RUN and DONE must be ignored
      @(posedge clk); #1;
      start = 1'b1;
      dividend = 8'd100;
      divisor = 8'd7;
      sb.push_back(model(8'd100, 8'd7));
      @(posedge clk); #1;
      e = sb.pop_front();
      dc = int'(e.lat) + 1;
      for (int c = 1; c <= dc; c++) begin
         start = (c == 3 || c == dc);
         dividend = start ? 8'd50 : 8'd100;
         divisor = start ? 8'd5 : 8'd7;
         if (c == dc) begin
            check("ign_done", done, 1);
            check_result("ign", e);
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      check("ign_busy_low", busy, 0);
      check("ign_done_low", done, 0);
      check_result("ign_hold", e);

      // reset in cycle 4 of an operation discards it
      start = 1'b1;
      dividend = 8'd100;
      divisor = 8'd7;
      sb.push_back(model(8'd100, 8'd7));
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      sb.delete();
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_q", quotient, 0);
      check("mid_rst_r", remainder, 0);
      check("mid_rst_dz", div_by_zero, 0);
      run_div(8'd20, 8'd6);

`ifdef SIGNED_DIV_EN
      run_div(8'hF9, 8'd2);
      run_div(8'd7, 8'hFE);
      run_div(8'h80, 8'hFF);
      run_div(8'hF0, 8'd0);
`endif

      for (int i = 0; i < 20; i++) run_div(8'($urandom), 8'($urandom_range(0, 255)));

      check("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Sequential radix-2 restoring integer divider, the inverse datapath to the Booth multiplier.
- Accepts a dividend/divisor pair on a start pulse and produces one quotient bit per clock.
- Each trial subtraction is done by the existing carry_lookahead_adder, computing R + ~D + 1.
- Intended for the arithmetic unit alongside the multiplier, sharing its start/done handshake style.

Parameters:
N, 8, operand width in bits for dividend, divisor, quotient and remainder.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  synchronous active-low reset.
start  input  1  request; accepted only when busy=0.
dividend  input  N  numerator, sampled on accepted start.
divisor  input  N  denominator, sampled on accepted start.
busy  output  1  high from the cycle after an accepted start through the done cycle.
done  output  1  one-cycle pulse; quotient, remainder and div_by_zero are valid from this cycle.
quotient  output  N  result quotient, held until the next accepted start.
remainder  output  N  result remainder, held until the next accepted start.
div_by_zero  output  1  set with done when divisor==0; held with the results.

Behaviour:
- Single clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a clk edge), including mid-operation: state=IDLE; busy, done, div_by_zero, quotient, remainder and count all 0. Any in-flight operation is discarded.
- FSM states:
  - IDLE: start=1 latches the operands into Dreg and Qreg, clears Rreg (N+1 bits) and loads count=N. Go to RUN, or to DONE if divisor==0.
  - RUN: each cycle:
    - Form S = {Rreg[N-1:0], Qreg[N-1]} (N+1 bits).
    - Trial T = S + ~{1'b0,Dreg} + 1 via carry_lookahead_adder #(N+1) with CIN=1.
    - Carry-out 1 means no borrow: Rreg<=T and Qreg<={Qreg[N-2:0],1}. Otherwise Rreg<=S and Qreg<={Qreg[N-2:0],0}.
    - Decrement count; on the cycle count reaches 1, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- busy = (state != IDLE). start is ignored in RUN and DONE; no queuing.
- Latency:
  - Start accepted at edge k: done high in cycle k+N+1, next start accepted at edge k+N+2.
  - Divide by zero: done high in cycle k+1.
- Divide by zero: quotient={N{1'b1}}, remainder=dividend, div_by_zero=1. The adder is not used.
- Results:
  - quotient/remainder registers update only on the DONE transition; intermediate values are not visible.
  - div_by_zero clears on the next accepted start.
- Invariants:
  - Unsigned: dividend == quotient*divisor + remainder.
  - remainder < divisor when divisor != 0.

Optional Feature:
Macro SIGNED_DIV_EN.
- Defined:
  - Operands are two's complement.
  - IDLE latches absolute values and records sign_q = dividend[N-1]^divisor[N-1] and sign_r = dividend[N-1].
  - At DONE, quotient is negated if sign_q and remainder is negated if sign_r. Truncation is toward zero.
  - The negation adds one cycle: done appears at k+N+2.
  - Divide by zero still returns all-ones and the raw dividend.
  - Overflow case -2^(N-1)/-1 returns quotient=-2^(N-1), remainder=0.
- Undefined: unsigned only, latency exactly N+1.

Decomposition:
- Package div_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t
  - function clog2-based COUNT_W
  - constant DIV0_QUOTIENT (all ones)
- Sub-module: reuse carry_lookahead_adder (parameter N+1) as the trial subtractor.
- No new sub-module.

Test Plan:
- N=8, dividend=100, divisor=7, start at edge 0 -> busy from cycle 1; done in cycle 9 with quotient=14, remainder=2, div_by_zero=0.
- 255/1 -> quotient=255, remainder=0. 3/200 -> quotient=0, remainder=3.
- 5/0 -> done in cycle 1, quotient=8'hFF, remainder=5, div_by_zero=1. A following 9/3 -> quotient=3, remainder=0, div_by_zero=0.
- 100/7 running; start=1 with 50/5 during cycles 3 and 9 -> ignored; result still 14 r 2; busy low in cycle 10.
- rst_n=0 in cycle 4 of 100/7 -> next cycle busy=0, done=0, quotient=0, remainder=0. A fresh 20/6 -> 3 r 2.
- SIGNED_DIV_EN: -7/2 -> quotient=-3 (8'hFD), remainder=-1 (8'hFF), done at cycle 10. 7/-2 -> -3 r 1.
